// File: rtl/fir_mac_sequencer_if.sv
// Handshake and address/strobe bundle between the FIR MAC sequencer and its
// surroundings (upstream sample source, sample RAM, coefficient ROM, accumulator).
interface fir_mac_sequencer_if #(
    parameter int AddrLengthBits = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      sample_wr_en;
    logic                      sample_wr_zero;
    logic [AddrLengthBits-1:0] sample_wr_addr;
    logic [AddrLengthBits-1:0] sample_rd_addr;
    logic [AddrLengthBits-1:0] coeff_addr;
    logic                      acc_clear;
    logic                      acc_en;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output sample_wr_en,
        output sample_wr_zero,
        output sample_wr_addr,
        output sample_rd_addr,
        output coeff_addr,
        output acc_clear,
        output acc_en,
        output out_valid
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  sample_wr_en,
        input  sample_wr_zero,
        input  sample_wr_addr,
        input  sample_rd_addr,
        input  coeff_addr,
        input  acc_clear,
        input  acc_en,
        input  out_valid
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a single-multiplier FIR: zero-fills the sample RAM after reset,
// then per accepted sample walks NumTaps address pairs and times the MAC strobes.
module fir_mac_sequencer #(
    parameter int NumTaps        = 16,
    parameter int AddrLengthBits = 4,
    parameter int PipeLatency    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_mac_sequencer_if.master bus
);

    localparam int AW     = AddrLengthBits;
    localparam int DrainW = (PipeLatency > 1) ? $clog2(PipeLatency) : 1;

    localparam logic [AW-1:0]     LastTap   = AW'(NumTaps - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(PipeLatency - 1);
    localparam logic [AW:0]       TapsExt   = (AW + 1)'(NumTaps);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          init_cnt_q, init_cnt_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          newest_q, newest_d;
    logic [AW-1:0]          k_q, k_d;
    logic [DrainW-1:0]      drain_q, drain_d;
    logic                   out_valid_q, out_valid_d;
    logic [PipeLatency-1:0] mac_sr_q, mac_sr_d;
    logic [PipeLatency-1:0] clr_sr_q, clr_sr_d;

    logic                   mac_now_s;
    logic                   clr_now_s;
    logic [AW-1:0]          rd_addr_s;

    // Circular read address: newest minus k, wrapping at NumTaps rather than 2**AW.
    always_comb begin
        rd_addr_s = '0;
        if (newest_q >= k_q) begin
            rd_addr_s = newest_q - k_q;
        end else begin
            rd_addr_s = AW'({1'b0, newest_q} + TapsExt - {1'b0, k_q});
        end
    end

    // State register and all sequential bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            newest_q    <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            out_valid_q <= 1'b0;
            mac_sr_q    <= '0;
            clr_sr_q    <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            newest_q    <= newest_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            mac_sr_q    <= mac_sr_d;
            clr_sr_q    <= clr_sr_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        newest_d    = newest_q;
        k_d         = k_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == LastTap) begin
                    init_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (bus.in_valid) begin
                    newest_d = wr_ptr_q;
                    k_d      = '0;
                    state_d  = S_MAC;
                    if (wr_ptr_q == LastTap) begin
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                if (k_q == LastTap) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == LastDrain) begin
                    drain_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_INIT;
            end
        endcase
    end

    // Address/write-strobe decode; in_ready depends on state only.
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.sample_wr_en   = 1'b0;
        bus.sample_wr_zero = 1'b0;
        bus.sample_wr_addr = wr_ptr_q;
        bus.sample_rd_addr = '0;
        bus.coeff_addr     = '0;
        mac_now_s          = 1'b0;
        clr_now_s          = 1'b0;
        case (state_q)
            S_INIT: begin
                bus.sample_wr_en   = 1'b1;
                bus.sample_wr_zero = 1'b1;
                bus.sample_wr_addr = init_cnt_q;
            end
            S_IDLE: begin
                bus.in_ready     = 1'b1;
                bus.sample_wr_en = bus.in_valid;
            end
            S_MAC: begin
                bus.sample_rd_addr = rd_addr_s;
                bus.coeff_addr     = k_q;
                mac_now_s          = 1'b1;
                clr_now_s          = (k_q == '0);
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // Strobe delay lines matching the RAM/ROM read and multiplier pipeline.
    always_comb begin
        mac_sr_d    = '0;
        clr_sr_d    = '0;
        mac_sr_d[0] = mac_now_s;
        clr_sr_d[0] = clr_now_s;
        for (int i = 1; i < PipeLatency; i++) begin
            mac_sr_d[i] = mac_sr_q[i-1];
            clr_sr_d[i] = clr_sr_q[i-1];
        end
    end

    assign bus.acc_en    = mac_sr_q[PipeLatency-1];
    assign bus.acc_clear = clr_sr_q[PipeLatency-1];
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (NumTaps=16, PipeLatency=2).
module tb_fir_mac_sequencer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    fir_mac_sequencer_if #(.AddrLengthBits(4)) bus ();

    fir_mac_sequencer #(
        .NumTaps       (16),
        .AddrLengthBits(4),
        .PipeLatency   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic        out_ready;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [17:0] pack_exp(input logic ir, input logic we, input logic wz,
                                             input logic [3:0] wa, input logic [3:0] ra,
                                             input logic [3:0] ca, input logic cl,
                                             input logic en, input logic ov);
        return {ir, we, wz, wa, ra, ca, cl, en, ov};
    endfunction

    function automatic logic [17:0] pack_act();
        return {bus.in_ready, bus.sample_wr_en, bus.sample_wr_zero, bus.sample_wr_addr,
                bus.sample_rd_addr, bus.coeff_addr, bus.acc_clear, bus.acc_en, bus.out_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic r, input logic iv, input logic orr, input logic [17:0] e);
        vec_t v;
        v.rst_n     = r;
        v.in_valid  = iv;
        v.out_ready = orr;
        v.exp       = e;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (16) tick();
    endtask

    initial begin
        logic [17:0] act;
        logic [3:0]  a4;
        int          accepts;
        int          last_cyc;
        int          k;
        bit          done;
        bit          hit;

        n_vec  = 0;
        n_miss = 0;

        // Reset rows, zero-fill rows, single sample at row 18 (edge T at its end).
        for (int i = 0; i < 2; i++)
            add_row(1'b0, 1'b0, 1'b0, pack_exp(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        for (int c = 0; c < 16; c++) begin
            a4 = 4'(c);
            add_row(1'b1, 1'b0, 1'b0, pack_exp(1'b0, 1'b1, 1'b1, a4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        add_row(1'b1, 1'b1, 1'b0, pack_exp(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        for (int j = 0; j < 18; j++) begin
            logic [3:0] ra;
            logic [3:0] ca;
            ra = (j < 16) ? 4'(16 - j) : 4'd0;
            ca = (j < 16) ? 4'(j) : 4'd0;
            add_row(1'b1, 1'b1, 1'b1, pack_exp(1'b0, 1'b0, 1'b0, 4'd0, ra, ca,
                                               (j == 2), (j >= 2), 1'b0));
        end
        add_row(1'b1, 1'b1, 1'b1, pack_exp(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
        add_row(1'b1, 1'b1, 1'b0, pack_exp(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n         = tbl[i].rst_n;
            bus.in_valid  = tbl[i].in_valid;
            bus.out_ready = tbl[i].out_ready;
            @(negedge clk);
            act = pack_act();
            if (!tbl[i].exp[16]) act[15:11] = tbl[i].exp[15:11];
            check($sformatf("row%0d", i), 32'(act), 32'(tbl[i].exp));
            tick();
        end

        // 17 back-to-back samples: write pointer wraps at 16, 17th run reads 0,15..1.
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        accepts  = 0;
        last_cyc = 0;
        k        = -1;
        done     = 1'b0;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge clk);
            if (k >= 0) begin
                check($sformatf("b2b_rd_k%0d", k), 32'(bus.sample_rd_addr), 32'((16 - k) % 16));
                check($sformatf("b2b_coeff_k%0d", k), 32'(bus.coeff_addr), 32'(k));
                k++;
                if (k == 16) done = 1'b1;
            end else if (bus.in_ready) begin
                check($sformatf("b2b_wr_en_%0d", accepts), 32'(bus.sample_wr_en), 32'd1);
                check($sformatf("b2b_wr_addr_%0d", accepts), 32'(bus.sample_wr_addr), 32'(accepts % 16));
                if (accepts > 0)
                    check($sformatf("b2b_period_%0d", accepts), 32'(cyc - last_cyc), 32'd20);
                last_cyc = cyc;
                accepts++;
                if (accepts == 17) k = 0;
            end
            tick();
        end
        check("b2b_completed", 32'(done), 32'd1);
        bus.in_valid = 1'b0;

        // Result held in DONE while out_ready is low; in_valid ignored there.
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("hold_accept", 32'(bus.in_ready), 32'd1);
        tick();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.out_valid) hit = 1'b1;
            else tick();
        end
        check("hold_reached_done", 32'(hit), 32'd1);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("hold_ov_%0d", j), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold_acc_en_%0d", j), 32'(bus.acc_en), 32'd0);
            check($sformatf("hold_in_ready_%0d", j), 32'(bus.in_ready), 32'd0);
            check($sformatf("hold_wr_en_%0d", j), 32'(bus.sample_wr_en), 32'd0);
            tick();
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        check("release_ov_before", 32'(bus.out_valid), 32'd1);
        tick();
        @(negedge clk);
        check("release_ov_after", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset pulsed at MAC k=5 aborts, zero-fills again and restarts wr_ptr.
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("abort_k5_coeff", 32'(bus.coeff_addr), 32'd5);
        check("abort_k5_acc_en", 32'(bus.acc_en), 32'd1);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("abort_acc_en", 32'(bus.acc_en), 32'd0);
        check("abort_acc_clear", 32'(bus.acc_clear), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_rd_addr", 32'(bus.sample_rd_addr), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                tick();
                @(negedge clk);
            end
            check($sformatf("refill_wr_%0d", c),
                  32'({bus.sample_wr_en, bus.sample_wr_zero, bus.in_ready, bus.sample_wr_addr}),
                  32'({1'b1, 1'b1, 1'b0, 4'(c)}));
        end
        tick();
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("restart_in_ready", 32'(bus.in_ready), 32'd1);
        check("restart_wr", 32'({bus.sample_wr_en, bus.sample_wr_zero, bus.sample_wr_addr}),
              32'({1'b1, 1'b0, 4'd0}));
        tick();
        bus.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
